// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: sequential instruction prefetch queue with redirect flush.
// Define IFB_FLUSH_COUNT_EN to add the saturating flush_count output.
module instr_fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
`ifdef IFB_FLUSH_COUNT_EN
    output logic [15:0] flush_count,
`endif
    input  logic        instr_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d, drain_addr_q, drain_addr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            mem_req_q, instr_valid_q;
    logic [31:0]     pc_mem  [DEPTH];
    logic [31:0]     ins_mem [DEPTH];
    logic            ack, push, pop, space;
    logic [31:0]     redir_pc;

    always_comb begin
        ack          = mem_req_q && mem_ack;
        redir_pc     = redirect_pc & ~32'h3;
        push         = state_q == REQ && ack && !redirect_valid;
        pop          = instr_valid_q && instr_ready && !redirect_valid;
        count_d      = redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
        rd_ptr_d     = redirect_valid ? '0 : rd_ptr_q + AW'(pop);
        wr_ptr_d     = redirect_valid ? '0 : wr_ptr_q + AW'(push);
        space        = count_d < CW'(DEPTH);
        fetch_pc_d   = redirect_valid ? redir_pc : push ? fetch_pc_q + 32'd4 : fetch_pc_q;
        // DRAIN keeps presenting the abandoned address until memory acknowledges it
        drain_addr_d = state_q == REQ ? fetch_pc_q : drain_addr_q;
        state_d      = state_q == IDLE ? ((redirect_valid || count_q < CW'(DEPTH)) ? REQ : IDLE) :
                       state_q == REQ  ? (ack ? ((redirect_valid || space) ? REQ : IDLE)
                                              : (redirect_valid ? DRAIN : REQ)) :
                                         (ack ? REQ : DRAIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC;
            drain_addr_q  <= RESET_PC;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            drain_addr_q  <= drain_addr_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            mem_req_q     <= state_d != IDLE;
            instr_valid_q <= count_d != '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]  <= fetch_pc_q;
            ins_mem[wr_ptr_q] <= mem_rdata;
        end
    end

`ifdef IFB_FLUSH_COUNT_EN
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb flush_cnt_d = (redirect_valid && flush_cnt_q != 16'hFFFF) ? flush_cnt_q + 16'd1 : flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flush_cnt_q <= '0;
        else        flush_cnt_q <= flush_cnt_d;
    end

    assign flush_count = flush_cnt_q;
`endif

    assign mem_req     = mem_req_q;
    assign mem_addr    = state_q == DRAIN ? drain_addr_q : fetch_pc_q;
    assign instr_valid = instr_valid_q;
    assign instr       = ins_mem[rd_ptr_q];
    assign instr_pc    = pc_mem[rd_ptr_q];
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// tb_instr_fetch_buffer: randomized bench with a queue-based reference model of the fetch buffer.
module tb_instr_fetch_buffer;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        mem_req, mem_ack = 1'b0, redirect_valid = 1'b0, instr_valid, instr_ready = 1'b0;
    logic [31:0] mem_addr, mem_rdata = '0, redirect_pc = '0, instr, instr_pc;
`ifdef IFB_FLUSH_COUNT_EN
    logic [15:0] flush_count;
`endif

    instr_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
`ifdef IFB_FLUSH_COUNT_EN
        .flush_count(flush_count),
`endif
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr(instr),
        .instr_pc(instr_pc), .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Reference model: queue of {pc, word}, plus the single outstanding request.
    logic [63:0] mq[$];
    logic [31:0] m_fpc, m_addr;
    bit          m_act, m_disc, m_done;
    int          m_old;
    logic [15:0] m_fc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_fpc = RPC; m_addr = RPC; m_act = 0; m_disc = 0; m_fc = '0;
        end else begin
            m_old  = mq.size();
            m_done = m_act && mem_ack;
            if (redirect_valid) begin
                mq.delete();
                if (m_fc != 16'hFFFF) m_fc++;
                m_fpc = redirect_pc & ~32'h3;
            end else begin
                if (m_old > 0 && instr_ready) void'(mq.pop_front());
                if (m_done && !m_disc) begin
                    mq.push_back({m_addr, mem_rdata});
                    m_fpc = m_addr + 32'd4;
                end
            end
            if (m_act && !mem_ack) begin
                if (redirect_valid) m_disc = 1;
            end else begin
                m_act  = redirect_valid || (m_done ? mq.size() < DEPTH : m_old < DEPTH);
                m_addr = m_fpc;
                m_disc = 0;
            end
        end
    end

    task automatic compare();
        chk("mem_req", 32'(mem_req), 32'(m_act));
        if (m_act) chk("mem_addr", mem_addr, m_addr);
        chk("instr_valid", 32'(instr_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("instr_pc", instr_pc, mq[0][63:32]);
            chk("instr", instr, mq[0][31:0]);
        end
`ifdef IFB_FLUSH_COUNT_EN
        chk("flush_count", 32'(flush_count), 32'(m_fc));
`endif
    endtask

    int lat_mode = 0, wcnt = 0;

    task automatic step();
        @(negedge clk);
        compare();
        redirect_valid = 1'b0;
        if (!mem_req || mem_ack) wcnt = lat_mode < 0 ? int'($urandom_range(0, 3)) : lat_mode;
        mem_ack = 1'b0;
        if (mem_req) begin
            if (wcnt == 0) mem_ack = 1'b1;
            else wcnt--;
        end
        mem_rdata = mem_addr >> 2;
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
    endtask

    logic [31:0] old_addr;
    logic [15:0] fc_before;
    bit          found;

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_valid", 32'(instr_valid), 32'd0);
        chk("reset_addr", mem_addr, RPC);
        instr_ready = 1'b1;
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 1) chk("first_req", 32'(mem_req), 32'd1);
            if (k >= 2) begin
                chk("seq_valid", 32'(instr_valid), 32'd1);
                chk("seq_pc", instr_pc, 32'(4 * (k - 2)));
                chk("seq_word", instr, 32'(k - 2));
            end
        end

        instr_ready = 1'b0;
        repeat (10) step();
        chk("full_req_low", 32'(mem_req), 32'd0);
        chk("full_valid", 32'(instr_valid), 32'd1);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        step();
        redirect(32'h0000_0103);
        step();
        chk("redir_flush", 32'(instr_valid), 32'd0);
        chk("redir_addr", mem_addr, 32'h0000_0100);
        instr_ready = 1'b1;
        step();
        chk("redir_first_pc", instr_pc, 32'h0000_0100);
        repeat (4) step();

        lat_mode = 3;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = mem_req && !mem_ack;
        end
        chk("wait_found", 32'(found), 32'd1);
        old_addr = mem_addr;
        redirect(32'h0000_0040);
        step();
        chk("drain_hold", mem_addr, old_addr);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = mem_req && mem_addr != old_addr;
        end
        chk("drain_next", mem_addr, 32'h0000_0040);
        repeat (10) step();

        lat_mode = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = mem_ack && instr_valid;
        end
        chk("coinc_found", 32'(found), 32'd1);
        fc_before = m_fc;
        redirect(32'h0000_0200);
        step();
        chk("coinc_empty", 32'(instr_valid), 32'd0);
        chk("coinc_addr", mem_addr, 32'h0000_0200);
        chk("coinc_fc_model", 32'(m_fc), 32'(fc_before) + 32'd1);

        redirect(32'hFFFF_FFF8);
        step();
        step();
        chk("wrap_pc0", instr_pc, 32'hFFFF_FFF8);
        step();
        chk("wrap_pc1", instr_pc, 32'hFFFF_FFFC);
        step();
        chk("wrap_pc2", instr_pc, 32'h0000_0000);

        lat_mode = -1;
        for (int i = 0; i < 3000; i++) begin
            step();
            instr_ready = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 15) == 0)
                redirect($urandom_range(0, 1) ? $urandom : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)));
        end

        @(negedge clk);
        #1 rst_n = 1'b0;
        mem_ack = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk("midreset_req", 32'(mem_req), 32'd0);
        chk("midreset_valid", 32'(instr_valid), 32'd0);
        chk("midreset_addr", mem_addr, RPC);
        @(negedge clk);
        rst_n = 1'b1;
        lat_mode = 1;
        repeat (20) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/instr_fetch_buffer.md
# instr_fetch_buffer

Instruction fetch unit with a small prefetch queue, sitting directly upstream of the single-cycle MIPS datapath. Fetches sequential words from instruction memory over a req/ack handshake and buffers them with their PCs. Presents them to the decode/execute stage over a valid/ready interface. Jumps and taken branches are applied through a redirect port that flushes the queue and restarts fetch.

## Interface
- DEPTH, 4: queue entries; power of two, 2..16
- RESET_PC, 32'h0000_0000: first fetch address after reset
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- mem_req  out  1  fetch request to instruction memory
- mem_addr  out  32  byte address of the requested word; always word-aligned
- mem_ack  in  1  memory returns mem_rdata for the current request this cycle
- mem_rdata  in  32  instruction word, sampled only when mem_req && mem_ack
- redirect_valid  in  1  jump or taken branch; single-cycle pulse
- redirect_pc  in  32  new fetch target
- instr_valid  out  1  queue head holds an instruction
- instr  out  32  head instruction word
- instr_pc  out  32  byte address of the head instruction
- instr_ready  in  1  consumer accepts head this cycle

## Operation
- State register, three states:
  - IDLE: mem_req=0.
  - REQ: mem_req=1, mem_addr=fetch_pc.
  - DRAIN: mem_req=1, mem_addr held, response discarded.
- At most one request outstanding. mem_addr is stable while mem_req=1, and mem_req stays high until mem_ack.
- Space check: `space = count_next < DEPTH`. count_next includes this cycle's push and pop.
- IDLE transitions:
  - IDLE→REQ when count < DEPTH and no redirect.
  - On redirect in IDLE: fetch_pc←redirect_pc, queue flushed, go to REQ.
- REQ transitions:
  - On mem_ack: push {fetch_pc, mem_rdata} and set fetch_pc←fetch_pc+4. Stay in REQ if space, otherwise go to IDLE.
  - On redirect without ack: go to DRAIN. fetch_pc←redirect_pc, queue flushed.
  - On redirect with ack in the same cycle: response discarded, nothing pushed. fetch_pc←redirect_pc, queue flushed, go to REQ.
- DRAIN transitions:
  - mem_req stays high on the old address.
  - On mem_ack: data dropped; go to REQ.
  - A further redirect in DRAIN overwrites fetch_pc and keeps DRAIN. If it coincides with mem_ack, go to REQ.
- Pop when instr_valid && instr_ready; the read pointer advances.
- Priority rules:
  - Redirect beats pop; a same-cycle pop is ignored and the queue becomes empty.
  - Push and pop in the same cycle leave count unchanged.
- Address rules:
  - redirect_pc[1:0] is forced to 2'b00.
  - fetch_pc increments modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Queue: circular buffer with wrapping read/write pointers and a count of 0..DEPTH.
- instr and instr_pc are driven combinationally from the head entry. They are undefined when instr_valid=0.
- Reset values:
  - state=IDLE, fetch_pc=RESET_PC, count=0, pointers=0.
  - mem_req=0, instr_valid=0, mem_addr=RESET_PC.
  - Queue contents are not reset.

## Timing
- First request: mem_req rises in the first cycle after rst_n deasserts.
- Zero-wait memory (mem_ack tied to mem_req): instruction at RESET_PC has instr_valid=1 two cycles after reset release. After that, one instruction per cycle.
- Fetch-to-head latency: 1 cycle after the acknowledged edge.
- Redirect penalty with zero-wait memory: target instruction valid 2 cycles after the redirect cycle. Each memory wait cycle adds one cycle.
- Reset asserted mid-operation forces reset values immediately, including mem_req=0. In-flight memory transactions are abandoned.
- Outputs are registered except instr, instr_pc and mem_addr. Those three are muxes of registers only, with no input-to-output combinational paths.

## Configuration
- IFB_FLUSH_COUNT_EN:
  - Defined: adds output `flush_count` (out, 16 bits), a saturating counter of redirect cycles. It is reset to 0 and holds at 16'hFFFF.
  - Undefined: the port and counter are absent; behaviour is otherwise identical.

## Test plan
- Reset release, mem_ack tied to mem_req, instr_ready=1, memory word[n]=n → instr_pc sequence 0,4,8,… with instr=0,1,2,… and instr_valid high from cycle 2 continuously.
- instr_ready=0, DEPTH=4 → exactly 4 acks, then mem_req low with count=4. Raising instr_ready resumes fetch the cycle after the first pop; no word is lost or duplicated.
- Redirect to 32'h0000_0103 while 3 entries are queued → instr_valid=0 the next cycle. Next mem_addr=32'h0000_0100; first delivered instr_pc=32'h100.
- Memory with 3-cycle ack latency, redirect to 32'h40 during a wait → mem_addr holds the old address until ack and that word never appears. Next request is at 32'h40.
- Redirect coincident with mem_ack and pop → response discarded, queue empty, next mem_addr=redirect target. With the macro defined, flush_count increments by 1.
- Redirect to 32'hFFFF_FFF8 → delivered PCs FFFF_FFF8, FFFF_FFFC, 0000_0000.
